key_press_detector: RTL and testbench

//  Parametrised N-channel pushbutton front end for DE1-SoC games.
//  - Per key: 2-flop synchroniser, debounce filter, press/release edge pulses, debounced held level.
//  - Optional auto-repeat.
//  - Sits between the raw KEY pins and the game FSMs (tug-of-war, flappy-bird flap input).
//  - Each physical press yields exactly one press pulse.

---
 rtl/key_press_detector.sv | 136 +++++++++++++
 tb/tb_key_press_detector.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_press_detector.sv
// N-channel pushbutton front end: 2-flop sync, debounce, press/release pulses, held level.
// Optional auto-repeat of press pulses while held, enabled by defining KEY_REPEAT_EN.
module key_press_detector #(
    parameter int unsigned N_KEYS          = 4,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic              Clock,
    input  logic              RST_n,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] released,
    output logic [N_KEYS-1:0] held
);

    localparam int unsigned   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        HELD_LOCK = 2'd0,
        IDLE      = 2'd1,
        PRESSED   = 2'd2
    } state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic             sync1;
        logic             sync2;
        logic             level;
        logic             accepted;
        logic             accept;
        logic [CNT_W-1:0] cnt;
        logic             press_r;
        logic             release_r;
        logic             held_r;
        state_t           state;

        // Sync flops hold the raw pin; cleared flops read as "pressed" on active-low boards.
        assign level  = ACTIVE_LOW ? ~sync2 : sync2;
        assign accept = (level != accepted) && (cnt == CNT_LAST);

`ifdef KEY_REPEAT_EN
        logic [RPT_W-1:0] rpt;
        logic             rpt_first;
        logic             rpt_fire;

        assign rpt_fire = (rpt == (rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST));
`endif

        always_ff @(posedge Clock or negedge RST_n) begin
            if (!RST_n) begin
                sync1     <= 1'b0;
                sync2     <= 1'b0;
                accepted  <= 1'b1;
                cnt       <= '0;
                state     <= HELD_LOCK;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                held_r    <= 1'b0;
`ifdef KEY_REPEAT_EN
                rpt       <= '0;
                rpt_first <= 1'b1;
`endif
            end else begin
                sync1     <= key[i];
                sync2     <= sync1;
                press_r   <= 1'b0;
                release_r <= 1'b0;

                // A bounce back to the accepted level restarts the count.
                if (level == accepted) begin
                    cnt <= '0;
                end else if (accept) begin
                    accepted <= level;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end

`ifdef KEY_REPEAT_EN
                if (state != PRESSED) begin
                    rpt       <= '0;
                    rpt_first <= 1'b1;
                end
`endif

                case (state)
                    HELD_LOCK: begin
                        if (accept) state <= IDLE;
                    end
                    IDLE: begin
                        if (accept) begin
                            state   <= PRESSED;
                            press_r <= 1'b1;
                            held_r  <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (accept) begin
                            state     <= IDLE;
                            release_r <= 1'b1;
                            held_r    <= 1'b0;
                        end else begin
`ifdef KEY_REPEAT_EN
                            if (rpt_fire) begin
                                press_r   <= 1'b1;
                                rpt       <= '0;
                                rpt_first <= 1'b0;
                            end else begin
                                rpt <= rpt + RPT_W'(1);
                            end
`endif
                        end
                    end
                    default: begin
                        state  <= HELD_LOCK;
                        held_r <= 1'b0;
                    end
                endcase
            end
        end

        assign press[i]    = press_r;
        assign released[i] = release_r;
        assign held[i]     = held_r;
    end

endmodule

// File: tb/tb_key_press_detector.sv
// Directed bench for key_press_detector (N_KEYS=4, active-low, DEBOUNCE_CYCLES=4).
// Build with KEY_REPEAT_EN defined to exercise the auto-repeat expectations.
module tb_key_press_detector;

    logic       Clock;
    logic       RST_n;
    logic [3:0] key;
    logic [3:0] press;
    logic [3:0] released;
    logic [3:0] held;

    int total;
    int bad;
    int pc[4];
    int rc[4];
    int overlap;

    key_press_detector #(
        .N_KEYS(4),
        .ACTIVE_LOW(1'b1),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .Clock(Clock),
        .RST_n(RST_n),
        .key(key),
        .press(press),
        .released(released),
        .held(held)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one clock and sample 1 time unit after the edge; tally pulses.
    task automatic tick();
        @(posedge Clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            pc[i] += int'(press[i]);
            rc[i] += int'(released[i]);
        end
        if ((press & released) != 4'b0) overlap++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            pc[i] = 0;
            rc[i] = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_rep;
        total   = 0;
        bad     = 0;
        overlap = 0;
        clear_counts();
        key   = 4'hF;
        RST_n = 1'b0;

        // Reset state
        run(3);
        check("reset_press", 32'(press), 32'h0);
        check("reset_release", 32'(released), 32'h0);
        check("reset_held", 32'(held), 32'h0);
        RST_n = 1'b1;
        run(10);
        check("post_reset_no_pulse", 32'(pc[0] + pc[1] + pc[2] + pc[3] + rc[0] + rc[1] + rc[2] + rc[3]), 32'd0);

        // 1: single press on key 0, 6-cycle latency
        clear_counts();
        key[0] = 1'b0;
        run(5);
        check("t1_press_early", 32'(press), 32'h0);
        check("t1_held_early", 32'(held), 32'h0);
        tick();
        check("t1_press", 32'(press), 32'h1);
        check("t1_held", 32'(held), 32'h1);
        tick();
        check("t1_press_1cyc", 32'(press), 32'h0);
        run(13);
        check("t1_press_count", 32'(pc[0]), 32'd1);
        check("t1_held_still", 32'(held), 32'h1);
        key[0] = 1'b1;
        run(6);
        check("t1_release", 32'(released), 32'h1);
        check("t1_held_off", 32'(held), 32'h0);
        tick();
        check("t1_release_1cyc", 32'(released), 32'h0);

        // 2: key held through reset -> locked until released
        key[0] = 1'b0;
        run(10);
        RST_n = 1'b0;
        run(2);
        RST_n = 1'b1;
        clear_counts();
        run(15);
        check("t2_lock_no_press", 32'(pc[0]), 32'd0);
        check("t2_lock_held", 32'(held), 32'h0);
        key[0] = 1'b1;
        run(10);
        check("t2_lock_no_release", 32'(rc[0]), 32'd0);
        key[0] = 1'b0;
        run(5);
        check("t2_press_early", 32'(press), 32'h0);
        tick();
        check("t2_press", 32'(press), 32'h1);
        key[0] = 1'b1;
        run(10);

        // 3: bouncing key 1 is filtered
        clear_counts();
        for (int c = 0; c < 12; c++) begin
            key[1] = ((c / 2) % 2) != 0;
            tick();
        end
        key[1] = 1'b0;
        check("t3_bounce_no_press", 32'(pc[1]), 32'd0);
        check("t3_bounce_held", 32'(held), 32'h0);
        run(5);
        check("t3_press_early", 32'(press), 32'h0);
        tick();
        check("t3_press", 32'(press), 32'h2);
        key[1] = 1'b1;
        run(10);

        // 4: simultaneous keys 0 and 3
        key[0] = 1'b0;
        key[3] = 1'b0;
        run(6);
        check("t4_press", 32'(press), 32'h9);
        run(4);
        key[0] = 1'b1;
        key[3] = 1'b1;
        run(6);
        check("t4_release", 32'(released), 32'h9);
        check("t4_no_press", 32'(press), 32'h0);
        run(4);

        // 5: async reset mid-debounce aborts, key 2 must be re-pressed
        key[3] = 1'b0;
        run(8);
        check("t5_held3", 32'(held), 32'h8);
        key[2] = 1'b0;
        run(4);
        RST_n = 1'b0;
        #1;
        check("t5_async_held", 32'(held), 32'h0);
        check("t5_async_press", 32'(press), 32'h0);
        tick();
        RST_n = 1'b1;
        clear_counts();
        run(15);
        check("t5_no_press", 32'(pc[2] + pc[3]), 32'd0);
        key[2] = 1'b1;
        run(10);
        key[2] = 1'b0;
        run(6);
        check("t5_repress", 32'(press), 32'h4);

        // 6: long hold on key 0 (auto-repeat when enabled)
        key = 4'hF;
        run(12);
        key[0] = 1'b0;
        run(6);
        check("t6_press_T", 32'(press), 32'h1);
        for (int k = 1; k <= 30; k++) begin
            tick();
`ifdef KEY_REPEAT_EN
            exp_rep = (k == 10) || (k > 10 && ((k - 10) % 3) == 0);
`else
            exp_rep = 1'b0;
`endif
            check($sformatf("t6_repeat_T+%0d", k), 32'(press[0]), 32'(exp_rep));
        end
        key[0] = 1'b1;
        run(6);
        check("t6_release", 32'(released), 32'h1);
        clear_counts();
        run(10);
        check("t6_stop", 32'(pc[0]), 32'd0);

        check("no_press_release_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
